// File: rtl/mult_bist_pkg.sv
// Shared types and constants for the multiplier self-test driver.
// The optional directed (-1 x -1) vector is enabled by MULT_BIST_DIRECTED_EN.
package mult_bist_pkg;

  localparam int LFSR_W = 32;
  // Galois taps 32,22,2,1 -> feedback bits 31,21,1,0
  localparam logic [LFSR_W-1:0] LFSR_TAPS    = 32'h8020_0003;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 32'hACE1_2468;
  localparam int MC_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RAND,
    ST_RDRAIN,
    ST_RST,
    ST_DIR,
    ST_DDRAIN,
    ST_DONE
  } state_t;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/mult_bist_lfsr.sv
// 32-bit Galois LFSR; next_value is the state that will be registered this edge,
// so the caller can register data derived from it in the same cycle.
module mult_bist_lfsr
  import mult_bist_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  output logic [LFSR_W-1:0] next_value
);

  logic [LFSR_W-1:0] value;
  logic [LFSR_W-1:0] base;

  assign base       = load ? SEED : value;
  assign next_value = advance ? lfsr_step(base) : base;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= SEED;
    end else begin
      value <= next_value;
    end
  end

endmodule

// File: rtl/mult_bist_driver.sv
// Self-test driver: random operands to a registered multiplier, delayed reference
// compare, mismatch count. Directed -1 x -1 vector included when MULT_BIST_DIRECTED_EN.
module mult_bist_driver
  import mult_bist_pkg::*;
#(
  parameter int                A_W         = 20,
  parameter int                B_W         = 18,
  parameter int                LATENCY     = 2,
  parameter int                NUM_VECTORS = 500,
  parameter logic [LFSR_W-1:0] SEED        = DEFAULT_SEED
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic signed [A_W-1:0]     a_out,
  output logic signed [B_W-1:0]     b_out,
  output logic                      dut_reset,
  input  logic signed [A_W+B_W-1:0] z_in,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [MC_W-1:0]           mismatch_count
);

  localparam int P_W = A_W + B_W;
  localparam logic [15:0] LAST_VEC   = 16'(NUM_VECTORS - 1);
  localparam logic [15:0] LAST_DRAIN = 16'(LATENCY - 1);
  localparam logic [15:0] LAST_RST   = 16'(LATENCY);

  state_t                 state, state_next;
  logic [15:0]            cnt, cnt_next;
  logic                   start_accept;
  logic [LFSR_W-1:0]      lfsr_next;
  logic signed [A_W-1:0]  a_next;
  logic signed [B_W-1:0]  b_next;
  logic signed [P_W-1:0]  expected;
  logic                   push_valid;
  logic                   cmp_fail;
  logic                   dl_valid [LATENCY];
  logic [P_W-1:0]         dl_data  [LATENCY];

  mult_bist_lfsr #(.SEED(SEED)) u_lfsr (
    .clk        (clk),
    .reset      (reset),
    .load       (start_accept),
    .advance    (state_next == ST_RAND),
    .next_value (lfsr_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt + 16'd1;
    start_accept = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        cnt_next = cnt;
        if (start) begin
          start_accept = 1'b1;
          state_next   = ST_RAND;
          cnt_next     = '0;
        end
      end
      ST_RAND: begin
        if (cnt == LAST_VEC) begin
          state_next = ST_RDRAIN;
          cnt_next   = '0;
        end
      end
      ST_RDRAIN: begin
        if (cnt == LAST_DRAIN) begin
          state_next = ST_RST;
          cnt_next   = '0;
        end
      end
      ST_RST: begin
        if (cnt == LAST_RST) begin
`ifdef MULT_BIST_DIRECTED_EN
          state_next = ST_DIR;
`else
          state_next = ST_DONE;
`endif
          cnt_next   = '0;
        end
      end
`ifdef MULT_BIST_DIRECTED_EN
      ST_DIR: begin
        state_next = ST_DDRAIN;
        cnt_next   = '0;
      end
      ST_DDRAIN: begin
        if (cnt == LAST_DRAIN) begin
          state_next = ST_DONE;
          cnt_next   = '0;
        end
      end
`endif
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Operands follow the state being entered so they line up with the state register
  always_comb begin
    a_next = '0;
    b_next = '0;
    case (state_next)
      ST_RAND: begin
        a_next = lfsr_next[A_W-1:0];
        b_next = lfsr_next[LFSR_W-1 -: B_W];
      end
      ST_RDRAIN: begin
        a_next = a_out;
        b_next = b_out;
      end
`ifdef MULT_BIST_DIRECTED_EN
      ST_DIR: begin
        a_next = '1;
        b_next = '1;
      end
      ST_DDRAIN: begin
        a_next = a_out;
        b_next = b_out;
      end
`endif
      default: begin
        a_next = '0;
        b_next = '0;
      end
    endcase
  end

  assign expected = P_W'(a_out) * P_W'(b_out);

`ifdef MULT_BIST_DIRECTED_EN
  assign push_valid = (state == ST_RAND) || (state == ST_DIR);
`else
  assign push_valid = (state == ST_RAND);
`endif

  for (genvar gi = 0; gi < LATENCY; gi++) begin : g_dl
    logic           in_valid;
    logic [P_W-1:0] in_data;
    if (gi == 0) begin : g_head
      assign in_valid = push_valid;
      assign in_data  = expected;
    end else begin : g_tail
      assign in_valid = dl_valid[gi-1];
      assign in_data  = dl_data[gi-1];
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        dl_valid[gi] <= 1'b0;
      end else begin
        dl_valid[gi] <= in_valid && !start_accept;
      end
    end

    always_ff @(posedge clk) begin
      dl_data[gi] <= in_data;
    end
  end

  // The DUT must read zero on the last cycle it is held in reset
  always_comb begin
    cmp_fail = 1'b0;
    if (dl_valid[LATENCY-1]) begin
      cmp_fail = (z_in != dl_data[LATENCY-1]);
    end
    if ((state == ST_RST) && (cnt == LAST_RST)) begin
      cmp_fail = (z_in != '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_out          <= '0;
      b_out          <= '0;
      dut_reset      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      mismatch_count <= '0;
    end else begin
      a_out     <= a_next;
      b_out     <= b_next;
      dut_reset <= (state_next == ST_RST);
      done      <= (state == ST_DONE) && !start_accept;
      if (start_accept) begin
        busy <= 1'b1;
      end else if (state == ST_DONE) begin
        busy <= 1'b0;
      end
      if (start_accept) begin
        mismatch_count <= '0;
      end else if (cmp_fail && (mismatch_count != '1)) begin
        mismatch_count <= mismatch_count + 1'b1;
      end
    end
  end

  assign pass = done && (mismatch_count == '0);

endmodule

// File: tb/tb_mult_bist_driver.sv
// Bench for mult_bist_driver: behavioural registered multiplier with injectable
// bit-0 faults, checked cycle by cycle against a timeline model of each run.
module tb_mult_bist_driver;

  localparam int A_W  = 20;
  localparam int B_W  = 18;
  localparam int P_W  = A_W + B_W;
  localparam int L    = 2;
  localparam int NUM  = 500;
  localparam logic [31:0] SEED = 32'hACE1_2468;
`ifdef MULT_BIST_DIRECTED_EN
  localparam bit DIR_EN = 1'b1;
`else
  localparam bit DIR_EN = 1'b0;
`endif
  localparam int DONE_REL = DIR_EN ? (NUM + 3*L + 3) : (NUM + 2*L + 2);

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  start = 1'b0;
  logic signed [A_W-1:0] a_out;
  logic signed [B_W-1:0] b_out;
  logic                  dut_reset;
  logic [P_W-1:0]        z_in;
  logic                  busy, done, pass;
  logic [15:0]           mismatch_count;

  int n_checks = 0;
  int n_errors = 0;
  int cur_rel  = -1;
  int cyc      = 0;
  int run_base = 1 << 30;
  bit fault_all = 1'b0;
  bit flip_at [0:1023];
  logic [31:0] vec [NUM];

  logic signed [A_W-1:0] ar = '0;
  logic signed [B_W-1:0] br = '0;
  logic signed [P_W-1:0] z_reg = '0;

  mult_bist_driver #(
    .A_W(A_W), .B_W(B_W), .LATENCY(L), .NUM_VECTORS(NUM), .SEED(SEED)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .a_out(a_out), .b_out(b_out), .dut_reset(dut_reset), .z_in(z_in),
    .busy(busy), .done(done), .pass(pass), .mismatch_count(mismatch_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier under test: registered inputs, registered product
  always @(posedge clk) begin
    if (dut_reset) begin
      ar    <= '0;
      br    <= '0;
      z_reg <= '0;
    end else begin
      ar    <= a_out;
      br    <= b_out;
      z_reg <= P_W'(ar) * P_W'(br);
    end
  end

  always_comb begin : z_fault
    int r;
    r    = cyc - run_base;
    z_in = z_reg;
    if (fault_all || (r >= 0 && r < 1024 && flip_at[r])) z_in[0] = ~z_reg[0];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s rel=%0d: got %0h, expected %0h", tag, cur_rel, got, exp);
    end
  endtask

  function automatic bit is_cmp(input int r);
    return (r >= L && r < NUM + L) || (r == NUM + 2*L) || (DIR_EN && r == NUM + 3*L + 1);
  endfunction

  // Expected {a_out, b_out} in the cycle after run edge r
  function automatic logic [P_W-1:0] exp_ops(input int r);
    logic [31:0]    v;
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    a = '0;
    b = '0;
    if (r < NUM + L) begin
      v = (r < NUM) ? vec[r] : vec[NUM-1];
      a = v[A_W-1:0];
      b = v[31 -: B_W];
    end else if (DIR_EN && r >= NUM + 2*L + 1 && r <= NUM + 3*L + 1) begin
      a = '1;
      b = '1;
    end
    return {a, b};
  endfunction

  task automatic check_all_zero(input string pfx);
    check({pfx, "_a_out"},     64'($unsigned(a_out)), 64'd0);
    check({pfx, "_b_out"},     64'($unsigned(b_out)), 64'd0);
    check({pfx, "_dut_reset"}, 64'(dut_reset), 64'd0);
    check({pfx, "_busy"},      64'(busy), 64'd0);
    check({pfx, "_done"},      64'(done), 64'd0);
    check({pfx, "_pass"},      64'(pass), 64'd0);
    check({pfx, "_mc"},        64'(mismatch_count), 64'd0);
  endtask

  task automatic do_run(input string name, input int ignore_rel, input int reset_rel,
                        input bit all_flip, input int n_flips);
    int exp_mc;
    int err0;
    logic [P_W-1:0] ops;
    bit exp_done;
    exp_mc = 0;
    err0   = n_errors;
    for (int i = 0; i < 1024; i++) flip_at[i] = 1'b0;
    for (int i = 0; i < n_flips; i++) flip_at[$urandom_range(DONE_REL + 2, 0)] = 1'b1;
    fault_all = all_flip;
    @(negedge clk);
    start    = 1'b1;
    run_base = cyc + 1;
    for (int r = 0; r <= DONE_REL + 2; r++) begin
      @(negedge clk);
      cur_rel = r;
      start   = (r == ignore_rel);
      if (r == reset_rel) begin
        reset = 1'b0;
        #1;
        check_all_zero("abort");
        repeat (2) @(negedge clk);
        check_all_zero("abort_hold");
        reset = 1'b1;
        fault_all = 1'b0;
        $display("run %s: reset at rel %0d, errors in run %0d", name, r, n_errors - err0);
        return;
      end
      ops      = exp_ops(r);
      exp_done = (r >= DONE_REL);
      check("a_out",     64'($unsigned(a_out)), 64'(ops[P_W-1 -: A_W]));
      check("b_out",     64'($unsigned(b_out)), 64'(ops[B_W-1:0]));
      check("dut_reset", 64'(dut_reset), 64'(r >= NUM + L && r <= NUM + 2*L));
      check("busy",      64'(busy), 64'(!exp_done));
      check("done",      64'(done), 64'(exp_done));
      check("mc",        64'(mismatch_count), 64'(exp_mc));
      check("pass",      64'(pass), 64'(exp_done && exp_mc == 0));
      if (is_cmp(r) && (all_flip || flip_at[r])) exp_mc++;
    end
    cur_rel = -1;
    check("final_done", 64'(done), 64'd1);
    check("final_mc",   64'(mismatch_count), 64'(exp_mc));
    check("final_pass", 64'(pass), 64'(exp_mc == 0));
    fault_all = 1'b0;
    $display("run %s: mismatch_count=%0d expected=%0d pass=%0b errors in run %0d",
             name, mismatch_count, exp_mc, pass, n_errors - err0);
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] taps;
    taps = (32'd1 << 31) | (32'd1 << 21) | (32'd1 << 1) | 32'd1;
    v = SEED;
    for (int k = 0; k < NUM; k++) begin
      v = (v >> 1) ^ (v[0] ? taps : 32'd0);
      vec[k] = v;
    end

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    repeat ($urandom_range(5, 1)) @(negedge clk);
    check_all_zero("idle");

    do_run("golden", -1, -1, 1'b0, 0);
    repeat ($urandom_range(5, 1)) @(negedge clk);
    do_run("bit0_all", -1, -1, 1'b1, 0);
    repeat ($urandom_range(5, 1)) @(negedge clk);
    do_run("rand_flips", -1, -1, 1'b0, 24);
    repeat ($urandom_range(5, 1)) @(negedge clk);
    do_run("start_ignored", $urandom_range(55, 45), -1, 1'b0, 0);
    repeat ($urandom_range(5, 1)) @(negedge clk);
    do_run("reset_abort", -1, $urandom_range(105, 95), 1'b0, 0);
    repeat ($urandom_range(5, 1)) @(negedge clk);
    check_all_zero("post_reset");
    do_run("after_reset", -1, -1, 1'b0, 0);
    repeat ($urandom_range(5, 1)) @(negedge clk);
    do_run("rand_flips2", -1, -1, 1'b0, 60);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
